// File: rtl/oh_clkdiv_align_if.sv
// -----------------------------------------------------------------------------
// oh_clkdiv_align_if
// Bundles the control inputs and the generated clock/strobe outputs of the
// fast-to-slow clock divider. The interface is parameterised by DW, which is
// the width of the ratio configuration and of the phase counter.
//
// Signals:
//   en        run request, level-sensitive
//   divcfg    divide ratio N; 0 and 1 are treated as 2
//   slowclk   divided clock, registered
//   firstedge one fast-cycle pulse in the first cycle of each slow period
//   lastedge  one fast-cycle pulse in the last cycle of each slow period
//   phase     position within the slow period, 0..N-1
//   active    high while slow periods are being generated
//
// Modports:
//   master  the controller: drives en/divcfg, observes the outputs
//   slave   the divider: consumes en/divcfg, drives the outputs
// -----------------------------------------------------------------------------
interface oh_clkdiv_align_if #(
    parameter int DW = 8
);
    logic          en;
    logic [DW-1:0] divcfg;
    logic          slowclk;
    logic          firstedge;
    logic          lastedge;
    logic [DW-1:0] phase;
    logic          active;

    modport master (
        output en,
        output divcfg,
        input  slowclk,
        input  firstedge,
        input  lastedge,
        input  phase,
        input  active
    );

    modport slave (
        input  en,
        input  divcfg,
        output slowclk,
        output firstedge,
        output lastedge,
        output phase,
        output active
    );
endinterface

// File: rtl/oh_clkdiv_align.sv
// -----------------------------------------------------------------------------
// oh_clkdiv_align
// Programmable fast-to-slow clock divider. Generates a slow clock that is
// phase-aligned to the fast clock, together with single-cycle strobes that
// mark the first and last fast cycle of every slow period.
//
// The divide ratio is captured into nreg_r only when a period starts
// (IDLE->RUN or at a period boundary), so a ratio change never disturbs the
// period that is currently running. Dropping en lets the running period
// finish in full before returning to IDLE.
//
// Ports:
//   clk     fast clock, all logic on posedge
//   nreset  asynchronous active-low reset
//   io      oh_clkdiv_align_if.slave
//             in : en, divcfg
//             out: slowclk, firstedge, lastedge, phase, active (all flops)
// -----------------------------------------------------------------------------
module oh_clkdiv_align #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               nreset,
    oh_clkdiv_align_if.slave   io
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DW-1:0] ZERO_DW = DW'(0);
    localparam logic [DW-1:0] ONE_DW  = DW'(1);
    localparam logic [DW-1:0] TWO_DW  = DW'(2);

    // Ratios below 2 cannot form a period with both a high and a low phase.
    function automatic logic [DW-1:0] clamp_ratio(input logic [DW-1:0] cfg);
        logic [DW-1:0] r;
        if (cfg < TWO_DW) begin
            r = TWO_DW;
        end else begin
            r = cfg;
        end
        return r;
    endfunction

    // High time ceil(N/2), computed one bit wider so N = 2^DW-1 cannot wrap.
    function automatic logic [DW:0] high_time(input logic [DW-1:0] n);
        logic [DW:0] sum;
        sum = {1'b0, n} + {{DW{1'b0}}, 1'b1};
        return sum >> 1;
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [DW-1:0] nreg_r;
    logic [DW-1:0] nreg_nx_s;
    logic [DW-1:0] phase_r;
    logic [DW-1:0] phase_nx_s;
    logic          slowclk_r;
    logic          slowclk_nx_s;
    logic          firstedge_r;
    logic          firstedge_nx_s;
    logic          lastedge_r;
    logic          lastedge_nx_s;
    logic          active_r;
    logic          active_nx_s;

    logic [DW-1:0] last_phase_s;
    logic          wrap_s;
    logic [DW:0]   high_s;
    logic [DW-1:0] phase_inc_s;

    // Period boundary detection and running-period high time.
    always_comb begin
        last_phase_s = nreg_r - ONE_DW;
        wrap_s       = (state_r == ST_RUN) && (phase_r == last_phase_s);
        high_s       = high_time(nreg_r);
        phase_inc_s  = phase_r + ONE_DW;
    end

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_nx_s     = state_r;
        nreg_nx_s      = nreg_r;
        phase_nx_s     = ZERO_DW;
        slowclk_nx_s   = 1'b0;
        firstedge_nx_s = 1'b0;
        lastedge_nx_s  = 1'b0;
        active_nx_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (io.en) begin
                    // Start the first period: phase 0 is always in the high half.
                    state_nx_s     = ST_RUN;
                    nreg_nx_s      = clamp_ratio(io.divcfg);
                    phase_nx_s     = ZERO_DW;
                    slowclk_nx_s   = 1'b1;
                    firstedge_nx_s = 1'b1;
                    lastedge_nx_s  = 1'b0;
                    active_nx_s    = 1'b1;
                end else begin
                    state_nx_s     = ST_IDLE;
                    nreg_nx_s      = nreg_r;
                    phase_nx_s     = ZERO_DW;
                    slowclk_nx_s   = 1'b0;
                    firstedge_nx_s = 1'b0;
                    lastedge_nx_s  = 1'b0;
                    active_nx_s    = 1'b0;
                end
            end

            ST_RUN: begin
                if (wrap_s) begin
                    if (io.en) begin
                        // Back-to-back period; ratio re-sampled here only.
                        state_nx_s     = ST_RUN;
                        nreg_nx_s      = clamp_ratio(io.divcfg);
                        phase_nx_s     = ZERO_DW;
                        slowclk_nx_s   = 1'b1;
                        firstedge_nx_s = 1'b1;
                        lastedge_nx_s  = 1'b0;
                        active_nx_s    = 1'b1;
                    end else begin
                        state_nx_s     = ST_IDLE;
                        nreg_nx_s      = nreg_r;
                        phase_nx_s     = ZERO_DW;
                        slowclk_nx_s   = 1'b0;
                        firstedge_nx_s = 1'b0;
                        lastedge_nx_s  = 1'b0;
                        active_nx_s    = 1'b0;
                    end
                end else begin
                    // Mid-period: advance phase, en is ignored until the wrap.
                    state_nx_s     = ST_RUN;
                    nreg_nx_s      = nreg_r;
                    phase_nx_s     = phase_inc_s;
                    slowclk_nx_s   = ({1'b0, phase_inc_s} < high_s);
                    firstedge_nx_s = 1'b0;
                    lastedge_nx_s  = (phase_inc_s == last_phase_s);
                    active_nx_s    = 1'b1;
                end
            end

            default: begin
                state_nx_s     = ST_IDLE;
                nreg_nx_s      = TWO_DW;
                phase_nx_s     = ZERO_DW;
                slowclk_nx_s   = 1'b0;
                firstedge_nx_s = 1'b0;
                lastedge_nx_s  = 1'b0;
                active_nx_s    = 1'b0;
            end
        endcase
    end

    // State, ratio and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            nreg_r      <= TWO_DW;
            phase_r     <= ZERO_DW;
            slowclk_r   <= 1'b0;
            firstedge_r <= 1'b0;
            lastedge_r  <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            nreg_r      <= nreg_nx_s;
            phase_r     <= phase_nx_s;
            slowclk_r   <= slowclk_nx_s;
            firstedge_r <= firstedge_nx_s;
            lastedge_r  <= lastedge_nx_s;
            active_r    <= active_nx_s;
        end
    end

    assign io.slowclk   = slowclk_r;
    assign io.firstedge = firstedge_r;
    assign io.lastedge  = lastedge_r;
    assign io.phase     = phase_r;
    assign io.active    = active_r;

endmodule

// File: tb/tb_oh_clkdiv_align.sv
// -----------------------------------------------------------------------------
// tb_oh_clkdiv_align
// Directed bench for oh_clkdiv_align (DW = 8). Outputs are packed into one
// 12-bit word {slowclk, firstedge, lastedge, active, phase[7:0]} and compared
// one cycle at a time against expected values.
// -----------------------------------------------------------------------------
module tb_oh_clkdiv_align;

    logic clk;
    logic nreset;
    int   n_checks;
    int   n_fail;

    oh_clkdiv_align_if #(.DW(8)) io ();

    oh_clkdiv_align #(.DW(8)) u_dut (
        .clk    (clk),
        .nreset (nreset),
        .io     (io)
    );

    // Fast clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs_word();
        return {io.slowclk, io.firstedge, io.lastedge, io.active, io.phase};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check phases [from, to) of an N-cycle period, one cycle each.
    task automatic check_phases(input string tag, input int n, input int from, input int to);
        logic [11:0] ev;
        int          hi;
        hi = (n + 1) / 2;
        for (int p = from; p < to; p++) begin
            ev = {(p < hi) ? 1'b1 : 1'b0,
                  (p == 0) ? 1'b1 : 1'b0,
                  (p == n - 1) ? 1'b1 : 1'b0,
                  1'b1,
                  8'(p)};
            chk($sformatf("%s p%0d", tag, p), obs_word(), ev);
            tick();
        end
    endtask

    task automatic check_period(input string tag, input int n);
        check_phases(tag, n, 0, n);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        nreset    = 1'b0;
        io.en     = 1'b0;
        io.divcfg = 8'd4;

        tick();
        tick();
        chk("reset", obs_word(), 12'h000);

        @(negedge clk);
        nreset = 1'b1;
        tick();
        chk("idle_en0_a", obs_word(), 12'h000);
        tick();
        chk("idle_en0_b", obs_word(), 12'h000);

        // N=4: first slowclk one cycle after en, pattern 1,1,0,0.
        io.en = 1'b1;
        tick();
        chk("n4_start", obs_word(), 12'hD00);
        check_period("n4a", 4);
        check_period("n4b", 4);

        // Change ratio at phase 1: current period stays 4, next is 6.
        check_phases("n4c", 4, 0, 1);
        io.divcfg = 8'd6;
        check_phases("n4c", 4, 1, 4);
        check_period("n6a", 6);

        // Ratio 5 picked up at the following boundary.
        io.divcfg = 8'd5;
        check_period("n6b", 6);
        check_period("n5a", 5);
        io.divcfg = 8'd8;
        check_period("n5b", 5);

        // N=8, drop en at phase 2: period completes, then idle.
        check_phases("n8_drop", 8, 0, 2);
        io.en = 1'b0;
        check_phases("n8_drop", 8, 2, 8);
        chk("idle_after_drop_a", obs_word(), 12'h000);
        tick();
        chk("idle_after_drop_b", obs_word(), 12'h000);
        tick();
        chk("idle_after_drop_c", obs_word(), 12'h000);
        io.en = 1'b1;
        tick();
        check_period("n8_restart", 8);

        // divcfg 0 and 1 clamp to 2.
        io.divcfg = 8'd0;
        check_period("n8_tail", 8);
        chk("clamp0_p0", obs_word(), 12'hD00);
        check_period("clamp0_a", 2);
        chk("clamp0_p1", obs_word(), 12'hD00);
        check_phases("clamp0_b", 2, 0, 1);
        chk("clamp0_p1_hand", obs_word(), 12'h301);
        tick();
        io.divcfg = 8'd1;
        check_period("clamp1_a", 2);
        check_period("clamp1_b", 2);

        // Maximum ratio 255: high time 128.
        io.divcfg = 8'd255;
        check_period("pre255", 2);
        io.divcfg = 8'd6;
        check_phases("n255", 255, 0, 127);
        chk("n255_p127", obs_word(), 12'h97F);
        tick();
        chk("n255_p128", obs_word(), 12'h180);
        check_phases("n255", 255, 128, 255);

        // Reset in the middle of an N=6 period.
        check_phases("n6_prerst", 6, 0, 3);
        chk("n6_p3", obs_word(), 12'h103);
        #2;
        nreset = 1'b0;
        #1;
        chk("rst_mid_async", obs_word(), 12'h000);
        tick();
        chk("rst_mid_hold", obs_word(), 12'h000);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        check_period("post_rst", 6);

        // Final stop: en low completes the period then idles.
        io.en = 1'b0;
        check_period("final", 6);
        chk("final_idle", obs_word(), 12'h000);
        tick();
        chk("final_idle_b", obs_word(), 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oh_clkdiv_align.md
# oh_clkdiv_align

Programmable fast-to-slow clock divider that generates a slow clock phase-aligned to the fast clock, plus single-cycle edge strobes. It is the generator counterpart of the fast/slow edge aligner: it produces the `slowclk` and `firstedge` relationship by construction rather than detecting it. It sits in the clock block feeding SERDES and link logic that run fast-domain datapaths against a slow-domain ratio.

## Interface
- `DW`, default 8: width of ratio config and phase counter; max ratio 2^DW-1.
- `clk`  in  1  fast clock; all logic on posedge.
- `nreset`  in  1  asynchronous active-low reset; clears all state immediately.
- `en`  in  1  run request; level-sensitive.
- `divcfg`  in  DW  divide ratio N (slow period = N `clk` cycles); values 0 and 1 are clamped to 2.
- `slowclk`  out  1  divided clock, registered, glitch-free.
- `firstedge`  out  1  one-`clk` pulse in the first fast cycle of each slow period (`slowclk` rising).
- `lastedge`  out  1  one-`clk` pulse in the last fast cycle of each slow period.
- `phase`  out  DW  current position within the slow period, 0..N-1.
- `active`  out  1  high while periods are being generated.

## Operation
- State: IDLE, RUN.
- Ratio register `nreg` holds the active N; `divcfg` is sampled (with clamping) only on IDLE->RUN and at every period boundary (`phase`==nreg-1 in RUN). Mid-period `divcfg` changes never alter the current period.
- High time H = ceil(N/2) = (N+1)>>1; `slowclk`=1 for `phase` 0..H-1, 0 for `phase` H..N-1. Odd N: high phase one cycle longer than low.
- IDLE: `slowclk`=0, `phase`=0, `firstedge`=`lastedge`=0, `active`=0. If `en`=1 at a posedge: load `nreg`, go RUN with `phase`=0, `slowclk`=1, `firstedge`=1, `active`=1.
- RUN: `phase` increments by 1 each cycle; at `phase`==nreg-1 it wraps to 0.
  - At wrap with `en`=1: reload `nreg` from `divcfg`, new period starts (`firstedge`=1, `slowclk`=1).
  - At wrap with `en`=0: go IDLE (`slowclk` stays 0, `active`=0, no `firstedge`).
  - `en` deassertion mid-period never truncates: the current period completes in full.
- `lastedge`=1 exactly when `phase`==nreg-1 in RUN; `firstedge`=1 exactly when `phase`==0 in RUN.
- N=2: `slowclk` toggles every cycle; `firstedge` and `lastedge` alternate.
- Arithmetic: `phase` and `nreg` are DW bits unsigned; compare `phase`==nreg-1 computed in DW bits (nreg>=2, so no underflow). H computed in DW+1 bits before shift, so N=2^DW-1 does not overflow.

## Timing
- Reset values: `slowclk`=0, `firstedge`=0, `lastedge`=0, `phase`=0, `active`=0; state IDLE, `nreg`=2.
- All outputs are flops driven from `clk` posedge; no combinational path from inputs to outputs.
- `en` rise sampled at posedge k -> `slowclk`, `firstedge`, `active` high after posedge k.
- `divcfg` change takes effect at the first `firstedge` after it is stable at the preceding period-boundary posedge; latency 0..N-1 cycles.
- `en` fall -> `active` low after the posedge that ends the current period.
- Reset asserted mid-period: outputs drop to reset values asynchronously; a partial slow period is acceptable only under reset. After release, IDLE until `en` is sampled high.

## Test plan
- Reset, `en`=1, `divcfg`=4 -> `slowclk` pattern 1,1,0,0 repeating; `firstedge` at `phase` 0, `lastedge` at `phase` 3; first `slowclk`=1 one cycle after `en`.
- `divcfg`=5 -> `slowclk` 1,1,1,0,0; `phase` 0..4 wrap; one `firstedge` per 5 cycles.
- Running N=4, change `divcfg` to 6 at `phase`=1 -> current period stays 4 cycles, next period 6 cycles (1,1,1,0,0,0).
- Running N=8, drop `en` at `phase`=2 -> period completes to `phase` 7, then `active`=0, `slowclk`=0, no further `firstedge`; re-raise `en` -> restart with `firstedge` next cycle.
- `divcfg`=0 and 1 -> behaves as N=2 (`slowclk` 1,0 alternating); `divcfg`=255 with DW=8 -> H=128, period 255.
- Assert `nreset` at `phase`=3 with N=6 -> all outputs 0 immediately; release with `en`=1 -> clean period from `phase` 0.
